// File: rtl/arbitrated_output_stage.sv
// N-to-1 valid/ready merger driven by an external one-hot grant arbiter.
// Granted channel data is registered with its source index; full throughput.
module arbitrated_output_stage #(
    parameter  int SIZE        = 4,
    parameter  int WIDTH       = 8,
    localparam int INDEX_WIDTH = $clog2(SIZE)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SIZE-1:0]         channel_valid,
    input  logic [SIZE*WIDTH-1:0]   channel_data,
    output logic [SIZE-1:0]         channel_ready,
    output logic [SIZE-1:0]         arbiter_requests,
    input  logic [SIZE-1:0]         arbiter_grant,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic [WIDTH-1:0]        output_data,
    output logic [INDEX_WIDTH-1:0]  output_channel,
    output logic                    protocol_error
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [WIDTH-1:0]       r_data;
    logic [INDEX_WIDTH-1:0] r_channel;
    logic                   r_error;

    logic                   w_load_enable;
    logic                   w_onehot0;
    logic                   w_grant_legal;
    logic                   w_transfer;
    logic [WIDTH-1:0]       w_mux_data;
    logic [INDEX_WIDTH-1:0] w_mux_index;

    // Reset gates loading so no channel is handshaken while state is clearing.
    assign w_load_enable    = ~reset & (~output_valid | output_ready);
    assign arbiter_requests = w_load_enable ? channel_valid : '0;

    assign w_onehot0     = (arbiter_grant & (arbiter_grant - SIZE'(1))) == '0;
    assign w_grant_legal = w_onehot0 &&
                           ((arbiter_grant & ~arbiter_requests) == '0);

    assign channel_ready = (w_load_enable && w_grant_legal)
                         ? (arbiter_grant & channel_valid) : '0;
    assign w_transfer    = |channel_ready;

    always_comb begin
        w_mux_data  = '0;
        w_mux_index = '0;
        for (int k = 0; k < SIZE; k++) begin
            if (channel_ready[k]) begin
                w_mux_data  = w_mux_data | channel_data[k*WIDTH +: WIDTH];
                w_mux_index = w_mux_index | INDEX_WIDTH'(k);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            EMPTY: begin
                if (w_transfer) w_state_next = FULL;
            end
            FULL: begin
                if (w_transfer)        w_state_next = FULL;
                else if (output_ready) w_state_next = EMPTY;
            end
            default: w_state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data    <= '0;
            r_channel <= '0;
        end else if (w_transfer) begin
            r_data    <= w_mux_data;
            r_channel <= w_mux_index;
        end
    end

    // Sticky until reset so software can observe a misbehaving arbiter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_load_enable && !w_grant_legal) begin
            r_error <= 1'b1;
        end
    end

    assign output_valid   = (r_state == FULL);
    assign output_data    = r_data;
    assign output_channel = r_channel;
    assign protocol_error = r_error;

endmodule

// File: tb/tb_arbitrated_output_stage.sv
// Directed bench for arbitrated_output_stage with a lowest-index arbiter model.
// Inputs change 1ns after the rising edge; outputs are checked on falling edges.
module tb_arbitrated_output_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  channel_valid;
    logic [31:0] channel_data;
    logic [3:0]  channel_ready;
    logic [3:0]  arbiter_requests;
    logic [3:0]  arbiter_grant;
    logic        output_valid;
    logic        output_ready;
    logic [7:0]  output_data;
    logic [1:0]  output_channel;
    logic        protocol_error;

    logic        force_en;
    logic [3:0]  force_val;

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    // Arbiter model: lowest requesting index wins, unless a grant is forced.
    assign arbiter_grant = force_en ? force_val
                         : (arbiter_requests & (~arbiter_requests + 4'd1));

    arbitrated_output_stage #(.SIZE(4), .WIDTH(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .channel_valid    (channel_valid),
        .channel_data     (channel_data),
        .channel_ready    (channel_ready),
        .arbiter_requests (arbiter_requests),
        .arbiter_grant    (arbiter_grant),
        .output_valid     (output_valid),
        .output_ready     (output_ready),
        .output_data      (output_data),
        .output_channel   (output_channel),
        .protocol_error   (protocol_error)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    initial begin
        force_en      = 1'b0;
        force_val     = 4'b0000;
        reset         = 1'b1;
        channel_valid = 4'b0000;
        channel_data  = '0;
        output_ready  = 1'b0;

        // Reset for 3 cycles with random inputs
        for (int i = 0; i < 3; i++) begin
            drive_edge();
            channel_valid = 4'($urandom);
            channel_data  = $urandom;
            output_ready  = 1'($urandom);
        end
        sample();
        check("rst_valid", 32'(output_valid), 32'd0);
        check("rst_data", 32'(output_data), 32'h00);
        check("rst_chan", 32'(output_channel), 32'd0);
        check("rst_err", 32'(protocol_error), 32'd0);
        check("rst_ready", 32'(channel_ready), 32'h0);

        // Single beat from channel 2
        drive_edge();
        reset              = 1'b0;
        channel_valid      = 4'b0100;
        channel_data       = '0;
        channel_data[23:16] = 8'hA5;
        output_ready       = 1'b1;
        sample();
        check("c2_ready", 32'(channel_ready), 32'h4);
        check("c2_req", 32'(arbiter_requests), 32'h4);

        // Back-pressure with channel 1 waiting
        drive_edge();
        channel_valid       = 4'b0010;
        channel_data[15:8]  = 8'h3C;
        output_ready        = 1'b0;
        sample();
        check("c2_ovalid", 32'(output_valid), 32'd1);
        check("c2_odata", 32'(output_data), 32'hA5);
        check("c2_ochan", 32'(output_channel), 32'd2);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) drive_edge();
            sample();
            check("bp_req", 32'(arbiter_requests), 32'h0);
            check("bp_ready", 32'(channel_ready), 32'h0);
            check("bp_valid", 32'(output_valid), 32'd1);
            check("bp_data", 32'(output_data), 32'hA5);
            check("bp_chan", 32'(output_channel), 32'd2);
        end
        drive_edge();
        output_ready = 1'b1;
        sample();
        check("rel_ready", 32'(channel_ready), 32'h2);
        check("rel_data", 32'(output_data), 32'hA5);
        drive_edge();
        channel_valid = 4'b0000;
        output_ready  = 1'b0;
        sample();
        check("c1_valid", 32'(output_valid), 32'd1);
        check("c1_data", 32'(output_data), 32'h3C);
        check("c1_chan", 32'(output_channel), 32'd1);
        drive_edge();
        output_ready = 1'b1;
        sample();
        check("c1_hold", 32'(output_data), 32'h3C);
        drive_edge();
        sample();
        check("drain1", 32'(output_valid), 32'd0);
        check("empty_keep", 32'(output_data), 32'h3C);

        // Channel 3 streams 8 beats back to back
        for (int i = 0; i <= 8; i++) begin
            drive_edge();
            if (i < 8) begin
                channel_valid       = 4'b1000;
                channel_data[31:24] = 8'(8'h10 + i);
            end else begin
                channel_valid = 4'b0000;
            end
            sample();
            if (i < 8) check("st_ready", 32'(channel_ready), 32'h8);
            if (i > 0) begin
                check("st_valid", 32'(output_valid), 32'd1);
                check("st_data", 32'(output_data), 32'(8'h10 + i - 1));
                check("st_chan", 32'(output_channel), 32'd3);
            end
        end
        drive_edge();
        sample();
        check("drain2", 32'(output_valid), 32'd0);

        // Illegal two-hot grant
        drive_edge();
        force_en      = 1'b1;
        force_val     = 4'b0110;
        channel_valid = 4'b0110;
        sample();
        check("ill_ready", 32'(channel_ready), 32'h0);
        check("ill_err0", 32'(protocol_error), 32'd0);
        drive_edge();
        force_en           = 1'b0;
        channel_valid      = 4'b0001;
        channel_data[7:0]  = 8'h55;
        sample();
        check("ill_err1", 32'(protocol_error), 32'd1);
        check("ill_novalid", 32'(output_valid), 32'd0);
        check("leg_ready", 32'(channel_ready), 32'h1);
        drive_edge();
        channel_valid = 4'b0000;
        sample();
        check("leg_data", 32'(output_data), 32'h55);
        check("leg_chan", 32'(output_channel), 32'd0);
        check("err_sticky", 32'(protocol_error), 32'd1);

        // Reset while full and back-pressured
        drive_edge();
        channel_valid       = 4'b0100;
        channel_data[23:16] = 8'h99;
        output_ready        = 1'b1;
        sample();
        check("pre_ready", 32'(channel_ready), 32'h4);
        drive_edge();
        channel_valid = 4'b0000;
        output_ready  = 1'b0;
        sample();
        check("pre_valid", 32'(output_valid), 32'd1);
        check("pre_data", 32'(output_data), 32'h99);
        drive_edge();
        reset = 1'b1;
        drive_edge();
        reset = 1'b0;
        sample();
        check("mr_valid", 32'(output_valid), 32'd0);
        check("mr_err", 32'(protocol_error), 32'd0);
        check("mr_data", 32'(output_data), 32'h00);
        drive_edge();
        channel_valid       = 4'b1000;
        channel_data[31:24] = 8'h77;
        output_ready        = 1'b1;
        sample();
        check("post_ready", 32'(channel_ready), 32'h8);
        drive_edge();
        channel_valid = 4'b0000;
        sample();
        check("post_valid", 32'(output_valid), 32'd1);
        check("post_data", 32'(output_data), 32'h77);
        check("post_chan", 32'(output_channel), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
